// File: rtl/pwm_multi_gen_if.sv
// Write port of pwm_multi_gen: duty/period register writes plus the one-cycle acknowledge.
interface pwm_multi_gen_if #(
  parameter int unsigned CBITS = 18,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned AW = $clog2(NCH + 1);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [CBITS-1:0] wr_data;
  logic             wr_ack;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM: one shared period counter, NCH double-buffered duty compares.
// Define PWM_CENTER_EN for center-aligned (up/down) counting; default is edge-aligned.
module pwm_multi_gen #(
  parameter int unsigned      CBITS      = 18,
  parameter int unsigned      NCH        = 4,
  parameter logic [CBITS-1:0] DEF_PERIOD = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  pwm_multi_gen_if.slave  bus,
  output logic [NCH-1:0]  pwm_o,
  output logic            period_tick
);
  localparam int unsigned AW = $clog2(NCH + 1);

  logic [CBITS-1:0] r_cnt;
  logic [CBITS-1:0] r_per_pend;
  logic [CBITS-1:0] r_per_act;
  logic [CBITS-1:0] r_duty_pend [NCH];
  logic [CBITS-1:0] r_duty_act  [NCH];
  logic             r_ack;
  logic             w_wr_ok;
  logic             w_wrap;

`ifdef PWM_CENTER_EN
  typedef enum logic {DIR_UP, DIR_DN} dir_t;
  dir_t r_dir;
  // A period ends on reaching 0 while counting down; a zero period wraps every cycle.
  assign w_wrap = (r_per_act == '0) || (r_dir == DIR_DN && r_cnt == '0);
`else
  assign w_wrap = (r_cnt == r_per_act);
`endif

  assign w_wr_ok    = bus.wr_en && (bus.wr_addr <= AW'(NCH));
  assign bus.wr_ack = r_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_per_pend  <= DEF_PERIOD;
      r_per_act   <= DEF_PERIOD;
      pwm_o       <= '0;
      period_tick <= 1'b0;
      r_ack       <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_duty_pend[i] <= '0;
        r_duty_act[i]  <= '0;
      end
`ifdef PWM_CENTER_EN
      r_dir <= DIR_UP;
`endif
    end else begin
      r_ack <= w_wr_ok;
      if (w_wr_ok) begin
        if (bus.wr_addr == AW'(NCH)) r_per_pend <= bus.wr_data;
        for (int unsigned i = 0; i < NCH; i++)
          if (bus.wr_addr == AW'(i)) r_duty_pend[i] <= bus.wr_data;
      end

      // Transfer samples pending before this cycle's write, so a write on a wrap waits a period.
      if (!en || w_wrap) begin
        r_per_act <= r_per_pend;
        for (int unsigned i = 0; i < NCH; i++) r_duty_act[i] <= r_duty_pend[i];
      end

      if (!en) begin
        r_cnt       <= '0;
        pwm_o       <= '0;
        period_tick <= 1'b0;
`ifdef PWM_CENTER_EN
        r_dir <= DIR_UP;
`endif
      end else begin
        period_tick <= w_wrap;
        for (int unsigned i = 0; i < NCH; i++) pwm_o[i] <= (r_cnt < r_duty_act[i]);
`ifdef PWM_CENTER_EN
        if (r_per_act == '0) begin
          r_cnt <= '0;
          r_dir <= DIR_UP;
        end else if (r_dir == DIR_UP) begin
          if (r_cnt == r_per_act) begin
            r_dir <= DIR_DN;
            r_cnt <= r_cnt - CBITS'(1);
          end else begin
            r_cnt <= r_cnt + CBITS'(1);
          end
        end else if (r_cnt == '0) begin
          r_dir <= DIR_UP;
          r_cnt <= (r_per_pend == '0) ? '0 : CBITS'(1);
        end else begin
          r_cnt <= r_cnt - CBITS'(1);
        end
`else
        r_cnt <= w_wrap ? '0 : r_cnt + CBITS'(1);
`endif
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen (edge-aligned build, CBITS=8, NCH=4, DEF_PERIOD=9).
module tb_pwm_multi_gen;
  localparam int unsigned CBITS = 8;
  localparam int unsigned NCH   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b0;
  logic [NCH-1:0] pwm_o;
  logic           period_tick;

  pwm_multi_gen_if #(.CBITS(CBITS), .NCH(NCH)) bus ();

  pwm_multi_gen #(.CBITS(CBITS), .NCH(NCH), .DEF_PERIOD(8'd9)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bus         (bus),
    .pwm_o       (pwm_o),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       we;
    logic [2:0] addr;
    logic [7:0] data;
    logic [3:0] pwm;
    logic       tick;
    logic       ack;
  } vec_t;

  vec_t tbl [16];
  int   n_chk = 0;
  int   n_pass = 0;
  int   hi [NCH];
  int   ticks, tick_at, acks;

  function automatic vec_t mk(input logic e, input logic we, input logic [2:0] a,
                              input logic [7:0] d, input logic [3:0] p, input logic t,
                              input logic k);
    vec_t v;
    v.en = e; v.we = we; v.addr = a; v.data = d; v.pwm = p; v.tick = t; v.ack = k;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock: drive at the falling edge, sample at the next falling edge.
  task automatic cyc(input logic e, input logic we, input logic [2:0] a, input logic [7:0] d);
    en          = e;
    bus.wr_en   = we;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic window(input int n, input int w1, input logic [2:0] a1, input logic [7:0] d1,
                        input int w2, input logic [2:0] a2, input logic [7:0] d2);
    for (int c = 0; c < NCH; c++) hi[c] = 0;
    ticks = 0; tick_at = -1; acks = 0;
    for (int i = 0; i < n; i++) begin
      if (i == w1)      cyc(1'b1, 1'b1, a1, d1);
      else if (i == w2) cyc(1'b1, 1'b1, a2, d2);
      else              cyc(1'b1, 1'b0, 3'd0, 8'd0);
      for (int c = 0; c < NCH; c++) if (pwm_o[c]) hi[c]++;
      if (period_tick) begin ticks++; tick_at = i; end
      if (bus.wr_ack) acks++;
    end
  endtask

  initial begin
    tbl[0] = mk(1'b0, 1'b1, 3'd0, 8'd3, 4'b0000, 1'b0, 1'b1);
    tbl[1] = mk(1'b0, 1'b1, 3'd5, 8'd1, 4'b0000, 1'b0, 1'b0);
    tbl[2] = mk(1'b1, 1'b0, 3'd0, 8'd0, 4'b0001, 1'b0, 1'b0);
    tbl[3] = mk(1'b1, 1'b0, 3'd0, 8'd0, 4'b0001, 1'b0, 1'b0);
    tbl[4] = mk(1'b1, 1'b0, 3'd0, 8'd0, 4'b0001, 1'b0, 1'b0);
    for (int k = 5; k <= 10; k++) tbl[k] = mk(1'b1, 1'b0, 3'd0, 8'd0, 4'b0000, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 3'd0, 8'd0, 4'b0000, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 3'd0, 8'd0, 4'b0001, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 3'd0, 8'd0, 4'b0001, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 3'd0, 8'd0, 4'b0001, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 3'd0, 8'd0, 4'b0000, 1'b0, 1'b0);

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    @(negedge clk);
    cyc(1'b0, 1'b0, 3'd0, 8'd0);
    cyc(1'b0, 1'b0, 3'd0, 8'd0);
    rst = 1'b0;
    check("reset_pwm", pwm_o, 0);
    check("reset_tick", period_tick, 0);
    check("reset_ack", bus.wr_ack, 0);

    // ch0 duty 3, period 10: table walks one and a half periods
    for (int k = 0; k < 16; k++) begin
      cyc(tbl[k].en, tbl[k].we, tbl[k].addr, tbl[k].data);
      check($sformatf("vec%0d_pwm", k), pwm_o, tbl[k].pwm);
      check($sformatf("vec%0d_tick", k), period_tick, tbl[k].tick);
      check($sformatf("vec%0d_ack", k), bus.wr_ack, tbl[k].ack);
    end

    // ch1=0, ch2=10 (above period), ch3=2, loaded through disable
    cyc(1'b0, 1'b1, 3'd2, 8'd10);
    cyc(1'b0, 1'b1, 3'd3, 8'd2);
    cyc(1'b0, 1'b1, 3'd1, 8'd0);
    check("ack_ch1", bus.wr_ack, 1);
    cyc(1'b0, 1'b0, 3'd0, 8'd0);
    window(20, -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);
    check("b_hi_ch0", hi[0], 6);
    check("b_hi_ch1", hi[1], 0);
    check("b_hi_ch2", hi[2], 20);
    check("b_hi_ch3", hi[3], 4);
    check("b_ticks", ticks, 2);
    check("b_tick_at", tick_at, 19);

    // ch3 2->7 written at cnt=4
    window(10, 4, 3'd3, 8'd7, -1, 3'd0, 8'd0);
    check("c_hi_ch3_cur", hi[3], 2);
    check("c_ack", acks, 1);
    check("c_tick_at", tick_at, 9);
    window(10, -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);
    check("c_hi_ch3_next", hi[3], 7);
    check("c_hi_ch0", hi[0], 3);

    // period=4 at cnt=5, ch0 duty=1 coincident with the wrap
    window(10, 5, 3'd4, 8'd4, 9, 3'd0, 8'd1);
    check("d_ticks_old", ticks, 1);
    check("d_tick_at_old", tick_at, 9);
    check("d_acks", acks, 2);
    window(5, -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);
    check("d_tick_at_new", tick_at, 4);
    check("d_ticks_new", ticks, 1);
    check("d_hi_ch0_delayed", hi[0], 3);
    check("d_hi_ch3_full", hi[3], 5);
    window(5, -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);
    check("d_hi_ch0_applied", hi[0], 1);
    check("d_tick_at2", tick_at, 4);

    // restore period 9, run to cnt=6, then reset with a concurrent write
    window(5, 0, 3'd4, 8'd9, -1, 3'd0, 8'd0);
    window(6, -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);
    check("e_no_tick_mid", ticks, 0);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 3'd0, 8'd5);
    rst = 1'b0;
    check("e_rst_pwm", pwm_o, 0);
    check("e_rst_tick", period_tick, 0);
    check("e_rst_ack", bus.wr_ack, 0);
    window(20, -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);
    check("e_hi_ch0", hi[0], 0);
    check("e_hi_ch2", hi[2], 0);
    check("e_hi_ch3", hi[3], 0);
    check("e_ticks", ticks, 2);
    check("e_tick_at", tick_at, 19);

    // disable mid-period, then fresh period on re-enable
    cyc(1'b0, 1'b1, 3'd0, 8'd9);
    cyc(1'b0, 1'b0, 3'd0, 8'd0);
    cyc(1'b1, 1'b0, 3'd0, 8'd0);
    cyc(1'b1, 1'b0, 3'd0, 8'd0);
    cyc(1'b1, 1'b0, 3'd0, 8'd0);
    check("f_pwm_on", pwm_o, 1);
    cyc(1'b0, 1'b0, 3'd0, 8'd0);
    check("f_dis_pwm", pwm_o, 0);
    check("f_dis_tick", period_tick, 0);
    window(10, -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);
    check("f_hi_ch0", hi[0], 9);
    check("f_tick_at", tick_at, 9);
    check("f_ticks", ticks, 1);

    // period 0: tick every cycle, high iff duty >= 1
    cyc(1'b0, 1'b1, 3'd4, 8'd0);
    cyc(1'b0, 1'b1, 3'd0, 8'd1);
    cyc(1'b0, 1'b0, 3'd0, 8'd0);
    window(4, -1, 3'd0, 8'd0, -1, 3'd0, 8'd0);
    check("g_ticks", ticks, 4);
    check("g_hi_ch0", hi[0], 4);
    check("g_hi_ch1", hi[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
